ram_data_part: RTL and testbench

//  Partitioned data RAM for the multiprogram processor: NUM_PROGS equal slots, one per program.
//  - Slot word 0 holds the saved PC; words 1..DATA_BASE-1 are the register spill area; the rest is data.
//  - Tracks active programs, switches programs round-robin on nextProgram, retires one on endProgram.
//  - Generalises the fixed two-program data RAM; sits between the datapath and the PC/control unit.

---
 rtl/proc_pkg.sv | 18 +
 rtl/prog_scheduler.sv | 66 ++++++
 rtl/ram_data_part.sv | 147 ++++++++++++++
 tb/tb_ram_data_part.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared definitions for the partitioned data RAM: width helper, slot layout, retire FSM states.
package proc_pkg;

  // Word 0 of every slot holds the saved PC.
  localparam int unsigned PC_WORD = 0;

  typedef enum logic [1:0] {
    StIdle,
    StClr,
    StSw
  } retire_state_e;

  // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_scheduler.sv
// Tracks active program slots and the current slot; round-robin switch, start and retire updates.
module prog_scheduler
  import proc_pkg::*;
#(
  parameter int unsigned NUM_PROGS = 4,
  localparam int unsigned ID_W = id_width(NUM_PROGS)
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [ID_W-1:0]      i_start_id,
  input  logic                 i_next,
  input  logic                 i_clr,
  input  logic                 i_sw,
  output logic [ID_W-1:0]      o_programa,
  output logic [NUM_PROGS-1:0] o_active_mask
);

  logic [NUM_PROGS-1:0] r_mask, w_mask_next;
  logic [ID_W-1:0]      r_prog, w_prog_next, w_rr;
  logic                 w_found;

  // First active slot after the current one, wrapping; slot 0 is always active.
  always_comb begin
    w_rr    = r_prog;
    w_found = 1'b0;
    for (int unsigned k = 1; k < NUM_PROGS; k++) begin
      if (!w_found && r_mask[ID_W'((32'(r_prog) + k) % NUM_PROGS)]) begin
        w_rr    = ID_W'((32'(r_prog) + k) % NUM_PROGS);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_mask_next = r_mask;
    if (i_start) begin
      w_mask_next[i_start_id] = 1'b1;
    end
    if (i_clr) begin
      w_mask_next[r_prog] = 1'b0;
    end
    w_mask_next[0] = 1'b1;

    w_prog_next = r_prog;
    if (i_sw) begin
      w_prog_next = '0;
    end else if (i_next) begin
      w_prog_next = w_rr;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_mask <= NUM_PROGS'(1);
      r_prog <= '0;
    end else begin
      r_mask <= w_mask_next;
      r_prog <= w_prog_next;
    end
  end

  assign o_programa    = r_prog;
  assign o_active_mask = r_mask;

endmodule

// File: rtl/ram_data_part.sv
// Partitioned data RAM: one equal slot per program, saved PC in word 0, register area, data area.
// Define RAM_DATA_BOUNDS_CHECK_EN to suppress and flag accesses that fall outside the slot.
module ram_data_part
  import proc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_PROGS  = 4,
  parameter int unsigned PROG_WORDS = 200,
  parameter int unsigned DATA_BASE  = 32,
  localparam int unsigned ID_W = id_width(NUM_PROGS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] endereco_leitura,
  input  logic [ADDR_WIDTH-1:0] endereco_escrita,
  input  logic                  we,
  input  logic                  offset_register,
  input  logic                  spc,
  input  logic                  lpc,
  input  logic [DATA_WIDTH-1:0] enderecoSpc,
  input  logic                  startProgram,
  input  logic [ID_W-1:0]       start_id,
  input  logic                  nextProgram,
  input  logic                  endProgram,
  output logic [DATA_WIDTH-1:0] q,
  output logic [ID_W-1:0]       programa,
  output logic [NUM_PROGS-1:0]  active_mask,
  output logic                  busy,
  output logic                  fault
);

  localparam int unsigned TOTAL  = NUM_PROGS * PROG_WORDS;
  localparam int unsigned OFF_W  = id_width(PROG_WORDS);
  localparam int unsigned PHYS_W = id_width(TOTAL);

  retire_state_e r_state, w_state_next;
  logic          w_clr, w_sw, w_idle, w_retire_go;

  logic [DATA_WIDTH-1:0] r_mem [TOTAL];
  logic [DATA_WIDTH-1:0] r_q, w_mem_wdata;
  logic                  r_fault, w_mem_we, w_rd_oob, w_wr_oob;
  logic [PHYS_W-1:0]     w_rd_idx, w_wr_idx, w_mem_waddr;
  logic [OFF_W-1:0]      w_rd_off, w_wr_off;
  int unsigned           w_base, w_slot_base, w_rd_local, w_wr_local;
  logic                  w_unused;

  assign w_rd_off = endereco_leitura[OFF_W-1:0];
  assign w_wr_off = endereco_escrita[OFF_W-1:0];
  assign w_unused = ^{endereco_leitura[ADDR_WIDTH-1:OFF_W], endereco_escrita[ADDR_WIDTH-1:OFF_W]};

  always_comb begin
    w_base      = (offset_register || spc || lpc) ? 0 : DATA_BASE;
    w_slot_base = 32'(programa) * PROG_WORDS;
    w_rd_local  = lpc ? PC_WORD : w_base + 32'(w_rd_off);
    w_wr_local  = spc ? PC_WORD : w_base + 32'(w_wr_off);
    w_rd_idx    = PHYS_W'((w_slot_base + w_rd_local) % TOTAL);
    w_wr_idx    = PHYS_W'((w_slot_base + w_wr_local) % TOTAL);
  end

`ifdef RAM_DATA_BOUNDS_CHECK_EN
  assign w_rd_oob = (w_rd_local >= PROG_WORDS);
  assign w_wr_oob = (w_wr_local >= PROG_WORDS);
`else
  assign w_rd_oob = 1'b0;
  assign w_wr_oob = 1'b0;
`endif

  // Retire FSM: CLR wipes the saved PC and mask bit, SW hands control back to slot 0.
  always_comb begin
    w_state_next = r_state;
    w_clr        = 1'b0;
    w_sw         = 1'b0;
    unique case (r_state)
      StIdle: if (endProgram && (programa != '0)) w_state_next = StClr;
      StClr: begin
        w_clr        = 1'b1;
        w_state_next = StSw;
      end
      StSw: begin
        w_sw         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  assign w_idle      = (r_state == StIdle);
  assign busy        = !w_idle;
  assign w_retire_go = w_idle && endProgram && (programa != '0);

  prog_scheduler #(
    .NUM_PROGS (NUM_PROGS)
  ) u_sched (
    .i_clock       (clock),
    .i_reset_n     (reset_n),
    .i_start       (startProgram && w_idle),
    .i_start_id    (start_id),
    .i_next        (nextProgram && w_idle && !w_retire_go),
    .i_clr         (w_clr),
    .i_sw          (w_sw),
    .o_programa    (programa),
    .o_active_mask (active_mask)
  );

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_wr_idx;
    w_mem_wdata = data;
    if (w_clr) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = PHYS_W'(w_slot_base + PC_WORD);
      w_mem_wdata = '0;
    end else if (w_idle) begin
      if (spc) begin
        w_mem_we    = 1'b1;
        w_mem_wdata = enderecoSpc - DATA_WIDTH'(w_slot_base);
      end else if (we && !w_wr_oob) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_fault <= 1'b0;
    end else begin
      r_q     <= w_rd_oob ? '0 : r_mem[w_rd_idx];
      r_fault <= w_rd_oob || (w_idle && we && !spc && w_wr_oob);
    end
  end

  assign q     = r_q;
  assign fault = r_fault;

endmodule

// File: tb/tb_ram_data_part.sv
// Directed bench for ram_data_part (NUM_PROGS=4, PROG_WORDS=200, DATA_BASE=32).
module tb_ram_data_part;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data = '0;
  logic [31:0] endereco_leitura = '0;
  logic [31:0] endereco_escrita = '0;
  logic        we = 1'b0;
  logic        offset_register = 1'b0;
  logic        spc = 1'b0;
  logic        lpc = 1'b0;
  logic [31:0] enderecoSpc = '0;
  logic        startProgram = 1'b0;
  logic [1:0]  start_id = '0;
  logic        nextProgram = 1'b0;
  logic        endProgram = 1'b0;
  logic [31:0] q;
  logic [1:0]  programa;
  logic [3:0]  active_mask;
  logic        busy;
  logic        fault;

  int n_tests = 0;
  int n_fail  = 0;

  ram_data_part #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_PROGS  (4),
    .PROG_WORDS (200),
    .DATA_BASE  (32)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .data             (data),
    .endereco_leitura (endereco_leitura),
    .endereco_escrita (endereco_escrita),
    .we               (we),
    .offset_register  (offset_register),
    .spc              (spc),
    .lpc              (lpc),
    .enderecoSpc      (enderecoSpc),
    .startProgram     (startProgram),
    .start_id         (start_id),
    .nextProgram      (nextProgram),
    .endProgram       (endProgram),
    .q                (q),
    .programa         (programa),
    .active_mask      (active_mask),
    .busy             (busy),
    .fault            (fault)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_next();
    nextProgram = 1'b1;
    tick();
    nextProgram = 1'b0;
  endtask

  task automatic start_prog(input logic [1:0] id);
    startProgram = 1'b1;
    start_id     = id;
    tick();
    startProgram = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_eq("rst_q", q, 32'h0);
    check_eq("rst_programa", 32'(programa), 32'd0);
    check_eq("rst_mask", 32'(active_mask), 32'h1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_fault", 32'(fault), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Data write at addr 5 lands on physical 37
    we = 1'b1; endereco_escrita = 32'd5; data = 32'hA5;
    tick();
    we = 1'b0; endereco_leitura = 32'd5;
    tick();
    check_eq("data_rd_5", q, 32'hA5);
    offset_register = 1'b1; endereco_leitura = 32'd37;
    tick();
    check_eq("reg_view_37", q, 32'hA5);

    // Start slot 2 and switch to it
    offset_register = 1'b0;
    start_prog(2'd2);
    check_eq("mask_start2", 32'(active_mask), 32'h5);
    pulse_next();
    check_eq("next_to_2", 32'(programa), 32'd2);

    // Register word 1, then spc beats a same-cycle we to word 1
    offset_register = 1'b1; we = 1'b1; endereco_escrita = 32'd1; data = 32'h11;
    tick();
    spc = 1'b1; enderecoSpc = 32'd450; data = 32'h77;
    tick();
    spc = 1'b0; we = 1'b0; lpc = 1'b1;
    tick();
    check_eq("lpc_saved_pc", q, 32'd50);
    lpc = 1'b0; endereco_leitura = 32'd1;
    tick();
    check_eq("spc_over_we", q, 32'h11);

    // Data words 6 and 5 in slot 2; read-during-write returns old data
    offset_register = 1'b0; we = 1'b1; endereco_escrita = 32'd6; data = 32'h44;
    tick();
    endereco_escrita = 32'd5; data = 32'h22;
    tick();
    data = 32'h33; endereco_leitura = 32'd5;
    tick();
    check_eq("rdw_old", q, 32'h22);
    we = 1'b0;
    tick();
    check_eq("rdw_new", q, 32'h33);

    // Retire slot 2; writes during busy are dropped
    endProgram = 1'b1;
    tick();
    endProgram = 1'b0;
    we = 1'b1; endereco_escrita = 32'd6; data = 32'h99;
    check_eq("ret_busy_clr", 32'(busy), 32'd1);
    tick();
    check_eq("ret_busy_sw", 32'(busy), 32'd1);
    check_eq("ret_mask", 32'(active_mask), 32'h1);
    check_eq("ret_prog_sw", 32'(programa), 32'd2);
    tick();
    we = 1'b0;
    check_eq("ret_idle", 32'(busy), 32'd0);
    check_eq("ret_prog0", 32'(programa), 32'd0);

    // Back into slot 2: saved PC cleared, data word 6 untouched
    start_prog(2'd2);
    pulse_next();
    lpc = 1'b1;
    tick();
    lpc = 1'b0;
    check_eq("pc_cleared", q, 32'h0);
    endereco_leitura = 32'd6;
    tick();
    check_eq("busy_we_dropped", q, 32'h44);

    // endProgram together with nextProgram: retire wins
    endProgram = 1'b1; nextProgram = 1'b1;
    tick();
    endProgram = 1'b0; nextProgram = 1'b0;
    check_eq("end_wins_prog", 32'(programa), 32'd2);
    check_eq("end_wins_busy", 32'(busy), 32'd1);
    tick();
    tick();
    check_eq("end_wins_done", 32'(programa), 32'd0);

    // Round-robin over mask 1011
    start_prog(2'd1);
    start_prog(2'd3);
    check_eq("mask_1011", 32'(active_mask), 32'hB);
    pulse_next();
    check_eq("rr_0_to_1", 32'(programa), 32'd1);
    pulse_next();
    check_eq("rr_1_to_3", 32'(programa), 32'd3);
    pulse_next();
    check_eq("rr_3_wrap_0", 32'(programa), 32'd0);
    pulse_next();
    check_eq("rr_0_to_1b", 32'(programa), 32'd1);
    pulse_next();
    pulse_next();

    // endProgram at slot 0 is ignored
    endProgram = 1'b1;
    tick();
    endProgram = 1'b0;
    check_eq("end0_busy", 32'(busy), 32'd0);
    check_eq("end0_mask", 32'(active_mask), 32'hB);
    check_eq("end0_prog", 32'(programa), 32'd0);

    // Reset asserted mid-retire
    pulse_next();
    endProgram = 1'b1;
    tick();
    endProgram = 1'b0;
    check_eq("clr_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_mask", 32'(active_mask), 32'h1);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_prog", 32'(programa), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Only slot 0 active: nextProgram stays on 0
    pulse_next();
    check_eq("only0_stay", 32'(programa), 32'd0);

    // Out-of-slot read: 32 + 170 >= 200
    offset_register = 1'b0; endereco_leitura = 32'd170;
    tick();
`ifdef RAM_DATA_BOUNDS_CHECK_EN
    check_eq("oob_fault", 32'(fault), 32'd1);
    check_eq("oob_q", q, 32'h0);
`else
    check_eq("oob_nofault", 32'(fault), 32'd0);
`endif
    endereco_leitura = 32'd5;
    tick();
    check_eq("oob_fault_clears", 32'(fault), 32'd0);
    check_eq("slot0_data_5", q, 32'hA5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
